// File: rtl/vga_timing_decoder.sv
// rtl/vga_timing_decoder.sv - recovers pixel coordinates, strobes and lock from an HS/VS/blank_n stream
// Define FRAME_ADDR_EN to build the linear pix_addr counter; otherwise pix_addr is tied to 0.
module vga_timing_decoder #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        blank_n,
  output logic        pix_valid,
  output logic [8:0]  row,
  output logic [9:0]  col,
  output logic        frame_start,
  output logic        line_end,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic [9:0]  line_total,
  output logic [18:0] pix_addr
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_TRAIN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [9:0] LP_H    = 10'(H_ACTIVE);
  localparam logic [8:0] LP_V    = 9'(V_ACTIVE);
  localparam logic [3:0] LP_LOCK = 4'(LOCK_FRAMES);

  logic       r_hs1, r_hs2, r_vs1, r_vs2, r_bl1, r_bl2;
  logic [9:0] r_pc;
  logic [8:0] r_lc;
  logic [9:0] r_hc;
  logic [1:0] r_state;
  logic [3:0] r_good;
  logic       r_line_bad;
  logic       r_pix_valid, r_frame_start, r_line_end, r_line_err, r_frame_err;
  logic [8:0] r_row;
  logic [9:0] r_col;
  logic [9:0] r_line_total;

  logic       w_hs_fall, w_vs_fall, w_bl_fall;
  logic [9:0] w_pc_inc;
  logic [8:0] w_lc_incl;
  logic       w_line_err, w_frame_err, w_good_frame;
  logic [3:0] w_good_inc;

  assign w_hs_fall = r_hs2 & ~r_hs1;
  assign w_vs_fall = r_vs2 & ~r_vs1;
  assign w_bl_fall = r_bl2 & ~r_bl1;

  assign w_pc_inc  = (r_pc == 10'h3FF) ? r_pc : r_pc + 10'd1;
  // A line ending in the same cycle as vs fall still belongs to the closing frame.
  assign w_lc_incl = (w_bl_fall && r_lc != 9'h1FF) ? r_lc + 9'd1 : r_lc;

  assign w_line_err   = w_bl_fall && (r_pc != LP_H);
  assign w_frame_err  = w_vs_fall && (w_lc_incl != LP_V) && (r_state != ST_SEARCH);
  assign w_good_frame = !(r_line_bad || w_line_err) && !w_frame_err;
  assign w_good_inc   = r_good + 4'd1;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hs1         <= 1'b1;
      r_hs2         <= 1'b1;
      r_vs1         <= 1'b1;
      r_vs2         <= 1'b1;
      r_bl1         <= 1'b0;
      r_bl2         <= 1'b0;
      r_pc          <= '0;
      r_lc          <= '0;
      r_hc          <= '0;
      r_state       <= ST_SEARCH;
      r_good        <= '0;
      r_line_bad    <= 1'b0;
      r_pix_valid   <= 1'b0;
      r_row         <= '0;
      r_col         <= '0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_line_total  <= '0;
    end else begin
      r_hs1 <= hs;
      r_hs2 <= r_hs1;
      r_vs1 <= vs;
      r_vs2 <= r_vs1;
      r_bl1 <= blank_n;
      r_bl2 <= r_bl1;

      if (w_bl_fall)  r_pc <= '0;
      else if (r_bl1) r_pc <= w_pc_inc;

      r_lc <= w_vs_fall ? 9'd0 : w_lc_incl;

      // An hs edge coinciding with vs fall opens the new frame's count.
      if (w_vs_fall) begin
        r_line_total <= r_hc;
        r_hc         <= {9'd0, w_hs_fall};
      end else if (w_hs_fall && r_hc != 10'h3FF) begin
        r_hc <= r_hc + 10'd1;
      end

      r_pix_valid <= r_bl1 && (r_state == ST_LOCKED);
      if (r_bl1) begin
        r_row <= r_lc;
        r_col <= r_pc;
      end
      r_frame_start <= w_vs_fall;
      r_line_end    <= w_bl_fall;
      r_line_err    <= w_line_err;
      r_frame_err   <= w_frame_err;

      if (w_vs_fall)       r_line_bad <= 1'b0;
      else if (w_line_err) r_line_bad <= 1'b1;

      case (r_state)
        ST_SEARCH: begin
          if (w_vs_fall) begin
            r_state <= ST_TRAIN;
            r_good  <= '0;
          end
        end
        ST_TRAIN: begin
          if (w_vs_fall) begin
            if (w_good_frame) begin
              r_good <= w_good_inc;
              if (w_good_inc == LP_LOCK) r_state <= ST_LOCKED;
            end else begin
              r_good <= '0;
            end
          end
        end
        ST_LOCKED: begin
          // Reacts to the registered error pulses, so locked drops one cycle after them.
          if (r_line_err || r_frame_err) begin
            r_state <= ST_TRAIN;
            r_good  <= '0;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

  assign pix_valid   = r_pix_valid;
  assign row         = r_row;
  assign col         = r_col;
  assign frame_start = r_frame_start;
  assign line_end    = r_line_end;
  assign locked      = (r_state == ST_LOCKED);
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;
  assign line_total  = r_line_total;

`ifdef FRAME_ADDR_EN
  logic [18:0] r_pix_addr;

  always_ff @(posedge vga_clk) begin
    if (reset)            r_pix_addr <= '0;
    else if (w_vs_fall)   r_pix_addr <= '0;
    else if (r_pix_valid) r_pix_addr <= r_pix_addr + 19'd1;
  end

  assign pix_addr = r_pix_addr;
`else
  assign pix_addr = '0;
`endif

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb/tb_vga_timing_decoder.sv - directed sync-stream bench with a pin-level reference model
`timescale 1ns/1ps
module tb_vga_timing_decoder;

  localparam int H     = 8;
  localparam int V     = 4;
  localparam int LOCKN = 2;
  localparam int HTOT  = 16;
  localparam int VTOT  = 9;
  localparam logic [2:0] IDLE = 3'b110;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b1;
  logic        hs = 1'b1;
  logic        vs = 1'b1;
  logic        blank_n = 1'b0;
  logic        pix_valid, frame_start, line_end, locked, line_err, frame_err;
  logic [8:0]  row;
  logic [9:0]  col;
  logic [9:0]  line_total;
  logic [18:0] pix_addr;

  int n_vec = 0;
  int n_bad = 0;
  int f = 0, vc = 0, hc = 0;

  vga_timing_decoder #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LOCKN)) dut (
    .vga_clk(vga_clk), .reset(reset), .hs(hs), .vs(vs), .blank_n(blank_n),
    .pix_valid(pix_valid), .row(row), .col(col), .frame_start(frame_start),
    .line_end(line_end), .locked(locked), .line_err(line_err), .frame_err(frame_err),
    .line_total(line_total), .pix_addr(pix_addr)
  );

  always #5 vga_clk = ~vga_clk;

  // 16x9 raster, 8x4 active; frame 4 has a 7-pixel line 1, frame 7 only 3 active lines.
  task automatic drive_pins();
    int act;
    int len;
    act = (f == 7) ? 3 : 4;
    len = (f == 4 && vc == 1) ? 7 : 8;
    blank_n = (vc < act) && (hc < len);
    hs      = !(hc >= 10 && hc < 13);
    vs      = !(vc >= 5 && vc < 7);
    reset   = (f == 0 && vc < 2) || (f == 10 && vc == 2 && hc >= 3 && hc < 6);
  endtask

  initial begin
    drive_pins();
    forever begin
      @(negedge vga_clk);
      if (hc == HTOT - 1) begin
        hc = 0;
        if (vc == VTOT - 1) begin
          vc = 0;
          f++;
        end else begin
          vc++;
        end
      end else begin
        hc++;
      end
      drive_pins();
    end
  end

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at f%0d v%0d h%0d: got %0d expected %0d", name, f, vc, hc, act, exp);
    end
  endtask

  function automatic bit at(int ff, int v, int h);
    return (f == ff) && (vc == v) && (hc == h);
  endfunction

  logic [2:0] m_last = IDLE;
  logic [2:0] m_prev = IDLE;
  int  m_run = 0, m_lines = 0, m_hcnt = 0, m_good = 0, e_lt = 0;
  bit  m_search = 1'b1, m_locked = 1'b0, m_drop = 1'b0, m_bad = 1'b0;

  initial begin
    logic [2:0] c, p;
    bit vsf, hsf, blf, e_pv, e_le_err, e_fr_err;
    int e_row, e_col, lines_incl;
    forever begin
      @(posedge vga_clk);
      #1;
      if (reset) begin
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_line_end", line_end, 0);
        chk("rst_locked", locked, 0);
        chk("rst_line_err", line_err, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_line_total", line_total, 0);
        chk("rst_pix_addr", pix_addr, 0);
        m_run = 0; m_lines = 0; m_hcnt = 0; m_good = 0; e_lt = 0;
        m_search = 1'b1; m_locked = 1'b0; m_drop = 1'b0; m_bad = 1'b0;
        m_prev = IDLE;
        m_last = IDLE;
      end else begin
        c = m_last;
        p = m_prev;
        hsf = p[2] & ~c[2];
        vsf = p[1] & ~c[1];
        blf = p[0] & ~c[0];

        e_pv  = c[0] && m_locked;
        e_row = m_lines;
        e_col = m_run;
        e_le_err = blf && (m_run != H);
        if (c[0]) m_run = (m_run < 1023) ? m_run + 1 : 1023;
        if (blf) m_run = 0;

        lines_incl = blf ? ((m_lines < 511) ? m_lines + 1 : 511) : m_lines;
        e_fr_err = vsf && (lines_incl != V) && !m_search;
        m_lines = vsf ? 0 : lines_incl;

        if (vsf) begin
          e_lt   = m_hcnt;
          m_hcnt = hsf ? 1 : 0;
        end else if (hsf && m_hcnt < 1023) begin
          m_hcnt++;
        end

        if (m_drop) begin
          m_locked = 1'b0;
          m_good   = 0;
          m_drop   = 1'b0;
        end
        if (e_le_err) m_bad = 1'b1;
        if (vsf) begin
          if (m_search) begin
            m_search = 1'b0;
            m_good   = 0;
          end else if (!m_locked) begin
            if (!m_bad && !e_fr_err) begin
              m_good++;
              if (m_good == LOCKN) m_locked = 1'b1;
            end else begin
              m_good = 0;
            end
          end
          m_bad = 1'b0;
        end
        if (m_locked && (e_le_err || e_fr_err)) m_drop = 1'b1;

        chk("pix_valid", pix_valid, e_pv);
        chk("frame_start", frame_start, vsf);
        chk("line_end", line_end, blf);
        chk("line_err", line_err, e_le_err);
        chk("frame_err", frame_err, e_fr_err);
        chk("locked", locked, m_locked);
        chk("line_total", line_total, e_lt);
        if (c[0]) begin
          chk("row", row, e_row);
          chk("col", col, e_col);
        end
`ifdef FRAME_ADDR_EN
        if (e_pv) chk("pix_addr", pix_addr, e_row * H + e_col);
`else
        chk("pix_addr_zero", pix_addr, 0);
`endif
        m_prev = m_last;
        m_last = {hs, vs, blank_n};
      end

      // Hand-computed anchors for the 16x9 raster.
      if (at(2, 5, 0)) chk("lit_lock_before_3rd_vs", locked, 0);
      if (at(2, 5, 1)) begin
        chk("lit_lock_after_3rd_vs", locked, 1);
        chk("lit_frame_start", frame_start, 1);
        chk("lit_line_total", line_total, 9);
      end
      if (at(3, 0, 1)) begin
        chk("lit_first_pv", pix_valid, 1);
        chk("lit_first_row", row, 0);
        chk("lit_first_col", col, 0);
        chk("lit_first_addr", pix_addr, 0);
      end
      if (at(3, 1, 2)) begin
`ifdef FRAME_ADDR_EN
        chk("lit_addr_r1c1", pix_addr, 9);
`else
        chk("lit_addr_r1c1", pix_addr, 0);
`endif
      end
      if (at(3, 3, 8)) begin
        chk("lit_last_pv", pix_valid, 1);
        chk("lit_last_row", row, 3);
        chk("lit_last_col", col, 7);
`ifdef FRAME_ADDR_EN
        chk("lit_last_addr", pix_addr, 31);
`else
        chk("lit_last_addr", pix_addr, 0);
`endif
      end
      if (at(4, 1, 8)) begin
        chk("lit_short_line_err", line_err, 1);
        chk("lit_short_still_locked", locked, 1);
      end
      if (at(4, 1, 9)) chk("lit_short_unlock", locked, 0);
      if (at(6, 5, 0)) chk("lit_relock_before", locked, 0);
      if (at(6, 5, 1)) chk("lit_relock_after", locked, 1);
      if (at(7, 5, 1)) begin
        chk("lit_frame_err", frame_err, 1);
        chk("lit_frame_err_locked", locked, 1);
      end
      if (at(7, 5, 2)) chk("lit_frame_err_unlock", locked, 0);
      if (at(9, 5, 1)) chk("lit_relock2", locked, 1);
      if (at(10, 2, 4)) begin
        chk("lit_reset_locked", locked, 0);
        chk("lit_reset_line_total", line_total, 0);
      end
      if (at(10, 5, 1)) begin
        chk("lit_search_frame_start", frame_start, 1);
        chk("lit_search_no_frame_err", frame_err, 0);
        chk("lit_search_locked", locked, 0);
      end
      if (at(11, 5, 1)) chk("lit_post_reset_one_good", locked, 0);
      if (at(12, 5, 1)) chk("lit_post_reset_relock", locked, 1);
    end
  end

  initial begin
    while (f < 13) @(posedge vga_clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_decoder.md
Name: vga_timing_decoder

Overview:
Receive-side counterpart of video_sync_generator. Consumes the HS/VS/blank_n triple as driven to the panel and recovers pixel coordinates, frame/line strobes and a lock indication. Sits on the vga_clk domain beside the overlay logic. Used as an in-system timing monitor and to drive coordinate-keyed overlays from the actual sync stream rather than from a free-running address counter.

Parameters:
H_ACTIVE, 640, expected active pixels per line (blank_n high run length)
V_ACTIVE, 480, expected active lines per frame
LOCK_FRAMES, 2, consecutive good frames required to enter LOCKED (1..15)

Ports:
vga_clk  input  1  pixel clock; all logic on rising edge
reset  input  1  synchronous, active-high
hs  input  1  horizontal sync, active low
vs  input  1  vertical sync, active low
blank_n  input  1  high during active video
pix_valid  output  1  row/col describe an active pixel of a locked frame
row  output  9  active line index 0..V_ACTIVE-1
col  output  10  active pixel index 0..H_ACTIVE-1
frame_start  output  1  one-cycle pulse on each detected vs falling edge
line_end  output  1  one-cycle pulse on each blank_n falling edge
locked  output  1  high in LOCKED state
line_err  output  1  one-cycle pulse: active run length != H_ACTIVE
frame_err  output  1  one-cycle pulse: active line count != V_ACTIVE at frame end
line_total  output  10  hs falling edges counted in the previous frame
pix_addr  output  19  linear active-pixel address (see Optional Feature)

Behaviour:
- Inputs registered once (s1), previous sample kept (s2); edges detected s1 vs s2. Reset loads s1/s2 = 1 for hs/vs and 0 for blank_n, so no spurious edge after reset.
- Reset values: all outputs 0; state SEARCH; internal counters 0; good_cnt 0.
- Pixel counter pc (10 b): increments each cycle s1.blank_n=1. Cleared on blank_n falling edge. Saturates at 1023.
- Line counter lc (9 b): increments on each blank_n falling edge. Cleared on vs falling edge. Saturates at 511.
- hs counter: increments on hs falling edge. Captured into line_total and cleared on vs falling edge.
- Latency: pix_valid/row/col are registered and valid the cycle after the sample enters s1, i.e. 2 vga_clk after blank_n at the pin. col = pc value for that pixel (first active pixel col=0); row = lc.
- line_end is a one-cycle pulse on each blank_n falling edge. line_err is also asserted on that edge if pc != H_ACTIVE.
- frame_start is a one-cycle pulse on each vs falling edge. frame_err is also asserted on that edge if lc != V_ACTIVE. Exception: frame_err is suppressed in SEARCH, where the first partial frame is not judged.
- FSM:
  SEARCH: wait for vs falling edge, then go to TRAIN with good_cnt=0.
  TRAIN: a frame is good if it ends on vs fall with no line_err since the previous vs fall and no frame_err. A good frame increments good_cnt; when good_cnt reaches LOCK_FRAMES, go to LOCKED. A bad frame clears good_cnt and stays in TRAIN.
  LOCKED: locked=1. Any line_err or frame_err returns the FSM to TRAIN with good_cnt=0 on the following cycle; locked drops the same cycle.
- pix_valid = s1.blank_n & locked (registered). row/col keep updating when unlocked.
- Simultaneous vs fall and blank_n fall in one cycle: the line is counted and checked first, then lc is cleared. The checked lc includes this line.
- Reset asserted mid-frame returns to SEARCH. The partial frame after reset never counts toward lock.

Optional Feature:
FRAME_ADDR_EN
- Defined: pix_addr is a 19-bit counter. Cleared on vs falling edge; increments after each cycle pix_valid=1. It equals row*H_ACTIVE+col for every valid pixel, and wraps at 2^19.
- Undefined: pix_addr is tied to 0 and no counter is built.

Test Plan:
- Nominal 800x525 timing (640x480 active, HS/VS active low), reset released mid-frame -> locked=0 through the first partial frame. locked=1 on the cycle after the 3rd vs fall (SEARCH, then 2 good frames). line_total=525.
- Locked stream, sample pixels -> first active pixel gives pix_valid=1, row=0, col=0. Last gives row=479, col=639. frame_start pulses once per frame, line_end 480 times per frame.
- Locked, inject one line with a 639-cycle blank_n run -> line_err pulses once at that blank_n fall. locked falls next cycle. Relock after 2 further good frames.
- Frame with only 479 active lines -> frame_err pulses at vs fall, and locked stays 0 / drops.
- Assert reset for 3 cycles at row 200 while locked -> all outputs 0, state SEARCH. Relock requires the partial frame plus 2 good frames.
- FRAME_ADDR_EN defined -> pix_addr=0 at row 0 col 0, 641 at row 1 col 1, 307199 at the last pixel. Undefined -> pix_addr constantly 0.
